bus_rr_scheduler: RTL and testbench
===================================

// Module: bus_rr_scheduler
// PURPOSE
//  Shares one packet bus among DRVRS driver FIFOs using round-robin arbitration.
//  Each grant pops one packet from the winning FIFO and decodes its destination field.
//  The packet is then pushed to one destination FIFO, or to all other FIFOs for broadcast.
//  Sits between the driver FIFO pndng/pop/D_pop side and the push/D_push side of bus_if.
// PARAMETERS
//  DRVRS      4      number of drivers/FIFOs on the bus (2..16)
//  PCKG_SZ    16     packet width in bits
//  ID_W       8      destination field width; field is D[PCKG_SZ-1 -: ID_W]
//  BROADCAST  8'hFF  destination value meaning "all drivers except source"
// PORTS
//  clk        in   1               bus clock, rising edge
//  reset      in   1               asynchronous, active-high
//  pndng      in   DRVRS           FIFO i has data; D_pop[i] valid (first-word fall-through)
//  D_pop      in   DRVRS x PCKG_SZ head-of-FIFO packet per driver
//  pop        out  DRVRS           one-hot, 1-cycle pop strobe to the granted FIFO
//  push       out  DRVRS           push strobe(s) to the destination FIFO(s)
//  D_push     out  PCKG_SZ         packet presented with push
//  busy       out  1               transfer in progress (state != IDLE)
//  grant_id   out  $clog2(DRVRS)   index of the current or last granted driver
//  err_dest   out  1               1-cycle pulse: packet dropped (bad destination)
//  pkt_cnt    out  16              delivered-packet count, wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pop=0, push=0, D_push=0, busy=0, grant_id=0,
//   err_dest=0, pkt_cnt=0, last_grant=DRVRS-1, so driver 0 wins the first arbitration.
//  All outputs are registered.
//  FSM: IDLE -> POP -> PUSH -> IDLE. One packet per 3 cycles maximum.
//  IDLE:
//   - If |pndng: pick the first set bit searching from last_grant+1, modulo DRVRS.
//   - Register grant_id=pick, data_q=D_pop[pick], pop=onehot(pick). Go to POP.
//   - If pndng==0: stay in IDLE.
//  POP:
//   - pop is high during this cycle only; next edge clears pop.
//   - dest=data_q[PCKG_SZ-1 -: ID_W].
//   - If dest==BROADCAST: push <= all ones & ~onehot(grant_id).
//   - Else if dest<DRVRS and dest!=grant_id: push <= onehot(dest).
//   - Else: push <= 0 and err_dest <= 1 (self-addressed or out of range).
//   - D_push <= data_q. Go to PUSH.
//  PUSH:
//   - push and D_push are valid for exactly this cycle; next edge clears push and err_dest.
//   - last_grant <= grant_id.
//   - pkt_cnt += 1 if push was nonzero (a broadcast counts as 1).
//   - Go to IDLE. D_push holds its value until the next transfer.
//  Latency: pndng sampled at edge k -> pop high in cycle k+1 -> push high in cycle k+2.
//  pndng deasserting after the grant edge does not abort the transfer; data is already latched.
//  A FIFO that becomes pending during POP/PUSH is considered at the next IDLE.
//  Fairness: with all pndng held high, grants rotate 0,1,..,DRVRS-1,0.
//  Reset mid-transfer: a packet already popped but not pushed is lost.
//   No pop/push glitch occurs on reset release.
// STRUCTURE
//  Package bus_sched_pkg holds:
//   - typedef enum {IDLE,POP,PUSH} sched_state_t
//   - localparam ID_W default
//   - function onehot()
//  Sub-module rr_arbiter (DRVRS): combinational pick/valid from req and last_grant.
//   The scheduler owns the last_grant register.
//  The top level holds the FSM, data_q, the dest decode and the counters.
// TESTING
//  1 Reset: hold reset 3 cycles, pndng=4'hF -> pop=0, push=0, pkt_cnt=0.
//    After release, first pop=4'b0001.
//  2 Unicast: pndng[2]=1, D_pop[2]=16'h01AB -> pop=4'b0100 in cycle k+1.
//    Then push=4'b0010 with D_push=16'h01AB in cycle k+2; pkt_cnt=1.
//  3 Broadcast: pndng[1]=1, D_pop[1]=16'hFF55 -> push=4'b1101, D_push=16'hFF55.
//    pkt_cnt increments by 1.
//  4 Bad dest: D_pop[0]=16'h0700 or 16'h0000 from driver 0 -> push stays 0.
//    err_dest pulses 1 cycle; pkt_cnt unchanged.
//  5 Fairness: pndng=4'hF held for 12 packets -> grant_id sequence 0,1,2,3 repeated 3 times.
//    Each pop is exactly 3 cycles apart.
//  6 Async reset asserted during POP -> pop/push drop immediately; state=IDLE.
//    After release, arbitration restarts at driver 0.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin packet bus scheduler.
package bus_sched_pkg;

  typedef enum logic [1:0] {IDLE, POP, PUSH} sched_state_t;

  localparam int unsigned ID_W = 8;

  // Up to 16 drivers; callers truncate to their own width.
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'b1 << idx;
  endfunction

endpackage

// File: rtl/bus_rr_scheduler_if.sv
// Driver-FIFO side of the packet bus: pending/head data in, pop/push strobes out.
interface bus_rr_scheduler_if #(
  parameter int unsigned DRVRS   = 4,
  parameter int unsigned PCKG_SZ = 16
);
  logic [DRVRS-1:0]              pndng;
  logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]              pop;
  logic [DRVRS-1:0]              push;
  logic [PCKG_SZ-1:0]            D_push;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request searching upward from last_grant+1.
module rr_arbiter #(
  parameter int unsigned DRVRS = 4
) (
  input  logic [DRVRS-1:0]         req,
  input  logic [$clog2(DRVRS)-1:0] last_grant,
  output logic [$clog2(DRVRS)-1:0] pick,
  output logic                     valid
);
  localparam int unsigned IdxW = $clog2(DRVRS);

  logic [IdxW-1:0] idx;

  assign valid = |req;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int unsigned k = DRVRS; k > 0; k--) begin
      idx = IdxW'((32'(last_grant) + k) % DRVRS);
      if (req[idx]) pick = idx;
    end
  end
endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin bus scheduler: pops one packet per grant and pushes it to its
// destination FIFO, or to every other FIFO on broadcast.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int unsigned     DRVRS     = 4,
  parameter int unsigned     PCKG_SZ   = 16,
  parameter int unsigned     DEST_W    = ID_W,
  parameter logic [DEST_W-1:0] BROADCAST = {DEST_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  bus_rr_scheduler_if.master       bus,
  output logic                     busy,
  output logic [$clog2(DRVRS)-1:0] grant_id,
  output logic                     err_dest,
  output logic [15:0]              pkt_cnt
);
  localparam int unsigned IdxW = $clog2(DRVRS);

  sched_state_t       state_q, state_d;
  logic [DRVRS-1:0]   pop_q, pop_d;
  logic [DRVRS-1:0]   push_q, push_d;
  logic [PCKG_SZ-1:0] d_push_q, d_push_d;
  logic [PCKG_SZ-1:0] data_q, data_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [IdxW-1:0]    arb_pick;
  logic               arb_valid;
  logic [DEST_W-1:0]  dest;

  rr_arbiter #(
    .DRVRS(DRVRS)
  ) u_arb (
    .req       (bus.pndng),
    .last_grant(last_q),
    .pick      (arb_pick),
    .valid     (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    pop_d    = '0;
    push_d   = '0;
    err_d    = 1'b0;
    d_push_d = d_push_q;
    data_d   = data_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    dest     = data_q[PCKG_SZ-1 -: DEST_W];
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_pick;
          data_d  = bus.D_pop[arb_pick];
          pop_d   = DRVRS'(onehot(4'(arb_pick)));
          state_d = POP;
        end
      end
      POP: begin
        if (dest == BROADCAST) begin
          push_d = {DRVRS{1'b1}} & ~DRVRS'(onehot(4'(grant_q)));
        end else if (32'(dest) < DRVRS && dest != DEST_W'(grant_q)) begin
          push_d = DRVRS'(onehot(dest[3:0]));
        end else begin
          err_d = 1'b1;
        end
        d_push_d = data_q;
        state_d  = PUSH;
      end
      PUSH: begin
        last_d = grant_q;
        // A broadcast counts once, a dropped packet not at all.
        if (|push_q) cnt_d = cnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pop_q    <= '0;
      push_q   <= '0;
      d_push_q <= '0;
      data_q   <= '0;
      grant_q  <= '0;
      last_q   <= IdxW'(DRVRS - 1);
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
      d_push_q <= d_push_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.pop    = pop_q;
  assign bus.push   = push_q;
  assign bus.D_push = d_push_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;
  assign err_dest   = err_q;
  assign pkt_cnt    = cnt_q;
endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Randomized bench for bus_rr_scheduler against a transaction-level reference model.
module tb_bus_rr_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [1:0]  grant_id;
  logic        err_dest;
  logic [15:0] pkt_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          last_gnt = 3;
  logic [15:0] exp_cnt  = '0;

  bus_rr_scheduler_if #(.DRVRS(4), .PCKG_SZ(16)) bus ();

  bus_rr_scheduler #(
    .DRVRS  (4),
    .PCKG_SZ(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .grant_id(grant_id),
    .err_dest(err_dest),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_next(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // Receivers of a packet sent by src: everyone but src on 0xFF, else the named driver.
  function automatic logic [3:0] exp_targets(input logic [15:0] pkt, input int src);
    logic [3:0] t;
    int d;
    d = int'(pkt[15:8]);
    for (int j = 0; j < 4; j++) begin
      if (d == 255) t[j] = (j != src);
      else          t[j] = (d == j) && (j != src);
    end
    return t;
  endfunction

  function automatic logic [15:0] rand_pkt();
    logic [7:0] d;
    case ($urandom_range(0, 5))
      0, 1, 2: d = 8'($urandom_range(0, 3));
      3:       d = 8'hFF;
      4:       d = 8'h07;
      default: d = 8'($urandom);
    endcase
    return {d, 8'($urandom)};
  endfunction

  // One arbitration slot starting in IDLE; D_pop must already be set.
  task automatic xfer(input logic [3:0] req);
    int w;
    logic [15:0] pkt;
    logic [3:0] tg;
    bus.pndng = req;
    w = pick_next(req, last_gnt);
    if (w < 0) begin
      step();
      check("idle_pop", 32'(bus.pop), 0);
      check("idle_busy", 32'(busy), 0);
      return;
    end
    pkt = bus.D_pop[w];
    tg  = exp_targets(pkt, w);
    step();
    check("pop", 32'(bus.pop), 32'(1) << w);
    check("grant_id", 32'(grant_id), 32'(w));
    check("busy", 32'(busy), 1);
    // Late changes to the FIFO side must not affect the latched packet.
    bus.pndng    = 4'($urandom);
    bus.D_pop[w] = 16'($urandom);
    step();
    check("pop_clr", 32'(bus.pop), 0);
    check("push", 32'(bus.push), 32'(tg));
    check("d_push", 32'(bus.D_push), 32'(pkt));
    check("err_dest", 32'(err_dest), 32'(tg == 4'b0));
    if (tg != 4'b0) exp_cnt = exp_cnt + 16'd1;
    step();
    check("push_clr", 32'(bus.push), 0);
    check("err_clr", 32'(err_dest), 0);
    check("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
    check("busy_idle", 32'(busy), 0);
    last_gnt = w;
  endtask

  initial begin
    reset     = 1'b1;
    bus.pndng = 4'hF;
    for (int i = 0; i < 4; i++) bus.D_pop[i] = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_pop", 32'(bus.pop), 0);
      check("rst_push", 32'(bus.push), 0);
      check("rst_cnt", 32'(pkt_cnt), 0);
      check("rst_busy", 32'(busy), 0);
    end
    reset = 1'b0;
    xfer(4'hF);  // driver 0 first, unicast to 1

    // Unicast from driver 2 to driver 1
    bus.D_pop[2] = 16'h01AB;
    xfer(4'b0100);

    // Broadcast from driver 1
    bus.D_pop[1] = 16'hFF55;
    xfer(4'b0010);

    // Out-of-range and self-addressed from driver 0
    bus.D_pop[0] = 16'h0700;
    xfer(4'b0001);
    bus.D_pop[0] = 16'h0000;
    xfer(4'b0001);

    // Nothing pending
    xfer(4'b0000);

    // Fairness: all pending for 12 packets
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 4; j++) bus.D_pop[j] = rand_pkt();
      xfer(4'hF);
    end

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < 4; j++) bus.D_pop[j] = rand_pkt();
      xfer(4'($urandom));
    end

    // Async reset during POP
    bus.D_pop[2] = 16'h0155;
    bus.pndng    = 4'b0100;
    step();
    check("mid_pop", 32'(bus.pop), 32'b0100);
    #2 reset = 1'b1;
    #1;
    check("arst_pop", 32'(bus.pop), 0);
    check("arst_push", 32'(bus.push), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_cnt", 32'(pkt_cnt), 0);
    exp_cnt  = '0;
    last_gnt = 3;
    bus.pndng = 4'b0000;
    step();
    step();
    reset = 1'b0;
    step();
    check("rel_pop", 32'(bus.pop), 0);
    check("rel_push", 32'(bus.push), 0);
    for (int j = 0; j < 4; j++) bus.D_pop[j] = rand_pkt();
    xfer(4'hF);  // restarts at driver 0
    for (int j = 0; j < 4; j++) bus.D_pop[j] = rand_pkt();
    xfer(4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
